// File: rtl/slice_rd_sched_pkg.sv
// Shared definitions for the slice read scheduler: FSM state encoding and the
// helper functions that size the slice-select and word-counter fields.
package slice_rd_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitSof,
    StRead,
    StGap,
    StDone
  } state_e;

  // Slice-select width; never narrower than one bit, even for a single slice.
  function automatic int unsigned sel_width(input int unsigned nbr_slices);
    return (nbr_slices > 1) ? $clog2(nbr_slices) : 1;
  endfunction

  // Word-counter width for 4-pixel words across the widest slice. The extra bit
  // lets a full-width chunk count be represented.
  function automatic int unsigned cnt_width(input int unsigned max_slice_width);
    return $clog2(max_slice_width >> 2) + 1;
  endfunction

endpackage

// File: rtl/slice_rd_sched.sv
// Slice read scheduler. Walks the slice FIFOs round-robin in chunks of
// chunk_words words, slices_per_line slices per line, frame_lines lines per
// frame, with hblank_cycles idle cycles after each line.
//
// Ports:
//   clk_out_int      output-domain clock, rising edge
//   rst_n            asynchronous active-low reset
//   flush            synchronous abort to idle
//   enable           allows leaving idle; sampled again only at end of frame
//   slices_per_line  slices per line (0 treated as 1)
//   chunk_words      words per slice chunk (0 treated as 1)
//   frame_lines      lines per frame (0 treated as 1)
//   hblank_cycles    idle cycles after each line
//   fifo_empty       per-slice FIFO empty
//   fifo_sof         per-slice start-of-frame; only slice 0 is used
//   rd_en            one-hot FIFO read strobe
//   rd_sel           slice currently granted
//   rd_last          last word of a chunk (qualified by rd_en)
//   line_end         one-cycle pulse after the last word of a line
//   frame_end        one-cycle pulse after the last word of a frame
//   underflow        sticky mid-line starvation flag
//   busy             scheduler not idle
module slice_rd_sched
  import slice_rd_sched_pkg::*;
#(
  parameter int unsigned MAX_NBR_SLICES  = 2,
  parameter int unsigned MAX_SLICE_WIDTH = 2560,
  localparam int unsigned SW = sel_width(MAX_NBR_SLICES),
  localparam int unsigned CW = cnt_width(MAX_SLICE_WIDTH)
) (
  input  logic                      clk_out_int,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      enable,
  input  logic [9:0]                slices_per_line,
  input  logic [CW-1:0]             chunk_words,
  input  logic [15:0]               frame_lines,
  input  logic [11:0]               hblank_cycles,
  input  logic [MAX_NBR_SLICES-1:0] fifo_empty,
  input  logic [MAX_NBR_SLICES-1:0] fifo_sof,
  output logic [MAX_NBR_SLICES-1:0] rd_en,
  output logic [SW-1:0]             rd_sel,
  output logic                      rd_last,
  output logic                      line_end,
  output logic                      frame_end,
  output logic                      underflow,
  output logic                      busy
);

  state_e      state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic [11:0] gap_cnt_q, gap_cnt_d;
  logic        underflow_q, underflow_d;
  logic        line_end_q, line_end_d;
  logic        frame_end_q, frame_end_d;

  // Last-index values with the zero-means-one substitution applied.
  logic [9:0]    sel_last;
  logic [CW-1:0] word_last;
  logic [15:0]   line_last;
  assign sel_last  = (slices_per_line == '0) ? '0 : slices_per_line - 10'd1;
  assign word_last = (chunk_words == '0) ? '0 : chunk_words - CW'(1);
  assign line_last = (frame_lines == '0) ? '0 : frame_lines - 16'd1;

  logic in_read, grant, sel_empty, starved, sel_is_last, gap_done;

  assign in_read = (state_q == StRead);

  always_comb begin
    rd_en     = '0;
    sel_empty = 1'b1;
    for (int s = 0; s < MAX_NBR_SLICES; s++) begin
      if (sel_q == SW'(s)) begin
        sel_empty = fifo_empty[s];
        rd_en[s]  = in_read & ~fifo_empty[s];
      end
    end
  end

  assign grant       = |rd_en;
  assign rd_last     = grant & (word_cnt_q == word_last);
  assign sel_is_last = (32'(sel_q) == 32'(sel_last));
  // An empty FIFO at the very start of a line is normal latency, not starvation.
  assign starved     = in_read & sel_empty & ((word_cnt_q != '0) | (sel_q != '0));
  assign gap_done    = ((gap_cnt_q + 12'd1) >= hblank_cycles);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    word_cnt_d  = word_cnt_q;
    line_cnt_d  = line_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    underflow_d = underflow_q;
    line_end_d  = 1'b0;
    frame_end_d = 1'b0;

    if (flush) begin
      state_d     = StIdle;
      sel_d       = '0;
      word_cnt_d  = '0;
      line_cnt_d  = '0;
      gap_cnt_d   = '0;
      underflow_d = 1'b0;
    end else if (fifo_sof[0] && (state_q inside {StRead, StGap, StDone})) begin
      // Restart: this cycle's rd_en still goes out, but its word is not counted.
      state_d    = StRead;
      sel_d      = '0;
      word_cnt_d = '0;
      line_cnt_d = '0;
      gap_cnt_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable) state_d = StWaitSof;
        end
        StWaitSof: begin
          if (fifo_sof[0]) begin
            state_d     = StRead;
            sel_d       = '0;
            word_cnt_d  = '0;
            line_cnt_d  = '0;
            gap_cnt_d   = '0;
            underflow_d = 1'b0;
          end
        end
        StRead: begin
          if (starved) underflow_d = 1'b1;
          if (grant) begin
            if (rd_last) begin
              word_cnt_d = '0;
              if (sel_is_last) begin
                sel_d      = '0;
                line_end_d = 1'b1;
                if (line_cnt_q == line_last) begin
                  state_d     = StDone;
                  frame_end_d = 1'b1;
                end else begin
                  line_cnt_d = line_cnt_q + 16'd1;
                  if (hblank_cycles != '0) begin
                    state_d   = StGap;
                    gap_cnt_d = '0;
                  end
                end
              end else begin
                sel_d = sel_q + SW'(1);
              end
            end else begin
              word_cnt_d = word_cnt_q + CW'(1);
            end
          end
        end
        StGap: begin
          if (gap_done) begin
            state_d   = StRead;
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + 12'd1;
          end
        end
        StDone: begin
          state_d = enable ? StWaitSof : StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_out_int or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      word_cnt_q  <= '0;
      line_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      underflow_q <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      word_cnt_q  <= word_cnt_d;
      line_cnt_q  <= line_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      underflow_q <= underflow_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign rd_sel    = sel_q;
  assign line_end  = line_end_q;
  assign frame_end = frame_end_q;
  assign underflow = underflow_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_slice_rd_sched.sv
// Directed bench for slice_rd_sched: nominal frame, hblank gap, starvation,
// mid-frame restart, flush with SOF, zero configuration and async reset.
module tb_slice_rd_sched;

  logic        clk_out_int = 1'b0;
  logic        rst_n       = 1'b0;
  logic        flush       = 1'b0;
  logic        enable      = 1'b0;
  logic [9:0]  slices_per_line = 10'd2;
  logic [10:0] chunk_words     = 11'd4;
  logic [15:0] frame_lines     = 16'd2;
  logic [11:0] hblank_cycles   = 12'd0;
  logic [1:0]  fifo_empty = 2'b00;
  logic [1:0]  fifo_sof   = 2'b00;
  logic [1:0]  rd_en;
  logic        rd_sel;
  logic        rd_last, line_end, frame_end, underflow, busy;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  slice_rd_sched #(
    .MAX_NBR_SLICES (2),
    .MAX_SLICE_WIDTH(2560)
  ) dut (
    .clk_out_int    (clk_out_int),
    .rst_n          (rst_n),
    .flush          (flush),
    .enable         (enable),
    .slices_per_line(slices_per_line),
    .chunk_words    (chunk_words),
    .frame_lines    (frame_lines),
    .hblank_cycles  (hblank_cycles),
    .fifo_empty     (fifo_empty),
    .fifo_sof       (fifo_sof),
    .rd_en          (rd_en),
    .rd_sel         (rd_sel),
    .rd_last        (rd_last),
    .line_end       (line_end),
    .frame_end      (frame_end),
    .underflow      (underflow),
    .busy           (busy)
  );

  always #5 clk_out_int = ~clk_out_int;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_out_int);
    #1;
  endtask

  // Flush to idle, step into WAIT_SOF, present one SOF; returns on READ cycle 1.
  task automatic start_frame();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    fifo_sof = 2'b01;
    tick();
    fifo_sof = 2'b00;
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_rd_en", 32'(rd_en), 0);
    check_eq("rst_rd_last", 32'(rd_last), 0);
    check_eq("rst_line_end", 32'(line_end), 0);
    check_eq("rst_frame_end", 32'(frame_end), 0);
    check_eq("rst_underflow", 32'(underflow), 0);
    rst_n = 1'b1;
    tick();
    enable = 1'b1;

    // Nominal frame: 2 slices x 4 words x 2 lines, no hblank
    start_frame();
    for (int k = 1; k <= 16; k++) begin
      check_eq($sformatf("nom_en_%0d", k), 32'(rd_en), (((k - 1) / 4) % 2 == 0) ? 1 : 2);
      check_eq($sformatf("nom_last_%0d", k), 32'(rd_last), (k % 4 == 0) ? 1 : 0);
      check_eq($sformatf("nom_lend_%0d", k), 32'(line_end), (k == 9) ? 1 : 0);
      check_eq($sformatf("nom_fend_%0d", k), 32'(frame_end), 0);
      tick();
    end
    check_eq("nom_c17_en", 32'(rd_en), 0);
    check_eq("nom_c17_lend", 32'(line_end), 1);
    check_eq("nom_c17_fend", 32'(frame_end), 1);
    tick();
    check_eq("nom_c18_busy", 32'(busy), 1);
    check_eq("nom_c18_en", 32'(rd_en), 0);
    check_eq("nom_c18_fend", 32'(frame_end), 0);

    // Hblank of 3 cycles
    hblank_cycles = 12'd3;
    start_frame();
    for (int k = 1; k <= 8; k++) begin
      check_eq($sformatf("hb_en_%0d", k), 32'(rd_en), (k <= 4) ? 1 : 2);
      tick();
    end
    check_eq("hb_lend", 32'(line_end), 1);
    for (int k = 9; k <= 11; k++) begin
      check_eq($sformatf("hb_gap_%0d", k), 32'(rd_en), 0);
      tick();
    end
    check_eq("hb_resume_en", 32'(rd_en), 1);
    check_eq("hb_resume_sel", 32'(rd_sel), 0);
    hblank_cycles = 12'd0;

    // Starvation of slice 1 mid-chunk
    start_frame();
    for (int k = 1; k <= 6; k++) tick();
    fifo_empty = 2'b10;
    #1;
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("stv_en_%0d", k), 32'(rd_en), 0);
      tick();
    end
    fifo_empty = 2'b00;
    #1;
    check_eq("stv_uf_set", 32'(underflow), 1);
    check_eq("stv_w2_en", 32'(rd_en), 2);
    check_eq("stv_w2_last", 32'(rd_last), 0);
    tick();
    check_eq("stv_w3_en", 32'(rd_en), 2);
    check_eq("stv_w3_last", 32'(rd_last), 1);
    tick();
    check_eq("stv_lend", 32'(line_end), 1);
    check_eq("stv_uf_sticky", 32'(underflow), 1);

    // Empty FIFO at line start is not an underflow
    fifo_empty = 2'b01;
    start_frame();
    check_eq("ls_uf_clr", 32'(underflow), 0);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("ls_en_%0d", k), 32'(rd_en), 0);
      tick();
    end
    check_eq("ls_uf", 32'(underflow), 0);
    fifo_empty = 2'b00;
    #1;
    check_eq("ls_en_go", 32'(rd_en), 1);

    // Mid-frame restart at line 1, word 2
    start_frame();
    for (int k = 1; k <= 10; k++) tick();
    fifo_sof = 2'b01;
    #1;
    check_eq("rs_honoured", 32'(rd_en), 1);
    tick();
    fifo_sof = 2'b00;
    #1;
    check_eq("rs_sel", 32'(rd_sel), 0);
    check_eq("rs_fend", 32'(frame_end), 0);
    check_eq("rs_lend", 32'(line_end), 0);
    for (int j = 1; j <= 4; j++) begin
      check_eq($sformatf("rs_s0_en_%0d", j), 32'(rd_en), 1);
      check_eq($sformatf("rs_s0_last_%0d", j), 32'(rd_last), (j == 4) ? 1 : 0);
      tick();
    end
    for (int j = 1; j <= 4; j++) tick();
    check_eq("rs_line0_lend", 32'(line_end), 1);
    check_eq("rs_line0_fend", 32'(frame_end), 0);

    // Flush and SOF together: flush wins
    flush    = 1'b1;
    fifo_sof = 2'b01;
    tick();
    flush    = 1'b0;
    fifo_sof = 2'b00;
    enable   = 1'b0;
    #1;
    check_eq("fl_busy", 32'(busy), 0);
    check_eq("fl_en", 32'(rd_en), 0);
    check_eq("fl_lend", 32'(line_end), 0);
    check_eq("fl_fend", 32'(frame_end), 0);
    enable = 1'b1;

    // Zero configuration: one slice, one-word chunks, two lines
    slices_per_line = 10'd0;
    chunk_words     = 11'd0;
    start_frame();
    check_eq("zc_c1_en", 32'(rd_en), 1);
    check_eq("zc_c1_last", 32'(rd_last), 1);
    check_eq("zc_c1_lend", 32'(line_end), 0);
    tick();
    check_eq("zc_c2_en", 32'(rd_en), 1);
    check_eq("zc_c2_last", 32'(rd_last), 1);
    check_eq("zc_c2_lend", 32'(line_end), 1);
    check_eq("zc_c2_fend", 32'(frame_end), 0);
    enable = 1'b0;
    tick();
    check_eq("zc_c3_lend", 32'(line_end), 1);
    check_eq("zc_c3_fend", 32'(frame_end), 1);
    check_eq("zc_c3_busy", 32'(busy), 1);
    check_eq("zc_c3_en", 32'(rd_en), 0);
    tick();
    check_eq("zc_c4_idle", 32'(busy), 0);

    // Asynchronous reset mid-frame
    enable          = 1'b1;
    slices_per_line = 10'd2;
    chunk_words     = 11'd4;
    start_frame();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_busy", 32'(busy), 0);
    check_eq("ar_en", 32'(rd_en), 0);
    check_eq("ar_sel", 32'(rd_sel), 0);
    tick();
    check_eq("ar_lend", 32'(line_end), 0);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
